// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART blocks.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START_BIT = 2'b01,
    DATA_BITS = 2'b10,
    STOP_BIT  = 2'b11
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter; rd_data shows the head combinationally.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == PTR_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge i_Clock) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers wrap through the low bits; a simultaneous write and pop keep count steady.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with an input FIFO; queued bytes are sent with no idle gap.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   IDLE      | line high, waiting for a byte in the FIFO
//   START_BIT | driving the start bit (low) for CLKS_PER_BIT cycles
//   DATA_BITS | driving shift_reg[index], LSB first, 8 bits
//   STOP_BIT  | driving the stop bit (high); pops the next byte on its last cycle
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int                IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  tx_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic             serial_nxt, active_nxt, done_nxt;
  logic             bit_last;
  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;

  assign o_Tx_Ready = !fifo_full && !i_Reset;
  assign bit_last   = (cnt == CNT_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .wr_en   (i_Tx_DV && o_Tx_Ready),
    .wr_data (i_Tx_Byte),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state, bit timer, bit index and shift register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      shift_reg <= shift_nxt;
    end
  end

  // Next-state logic; line level is derived from the current state and registered below.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = idx;
    shift_nxt  = shift_reg;
    pop        = 1'b0;
    serial_nxt = 1'b1;
    active_nxt = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_head;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = START_BIT;
        end
      end
      START_BIT: begin
        serial_nxt = 1'b0;
        active_nxt = 1'b1;
        if (bit_last) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = DATA_BITS;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        serial_nxt = shift_reg[idx];
        active_nxt = 1'b1;
        if (bit_last) begin
          cnt_nxt = '0;
          if (idx == IDX_LAST) begin
            state_nxt = STOP_BIT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      STOP_BIT: begin
        serial_nxt = 1'b1;
        active_nxt = 1'b1;
        if (bit_last) begin
          done_nxt = 1'b1;
          cnt_nxt  = '0;
          idx_nxt  = '0;
          // Chain straight into the next frame when a byte is already waiting.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_head;
            state_nxt = START_BIT;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered line outputs; forced to idle from the first reset edge.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Serial <= serial_nxt;
      o_Tx_Active <= active_nxt;
      o_Tx_Done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench: per-cycle comparison against a frame-timeline model plus a loopback decoder.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Tx_DV = 1'b0;
  logic [7:0] i_Tx_Byte = 8'h00;
  logic       o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done;

  int checks   = 0;
  int failures = 0;

  // Model: each accepted byte becomes a frame with an accept edge and a start cycle.
  int         cyc = 0;
  int         f_acc[$];
  int         f_st[$];
  logic [7:0] f_by[$];
  int         last_end = -1000;
  logic [7:0] acc_q[$];

  // Loopback decoder and done-pulse log.
  logic [7:0] rx_q[$];
  int         done_q[$];
  logic       rx_busy = 1'b0;
  int         rx_t0 = 0;
  logic [7:0] rx_byte = 8'h00;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Tx_DV     (i_Tx_DV),
    .i_Tx_Byte   (i_Tx_Byte),
    .o_Tx_Ready  (o_Tx_Ready),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Tx_Active (o_Tx_Active),
    .o_Tx_Done   (o_Tx_Done)
  );

  always #5 i_Clock = ~i_Clock;

  // One clock: drive inputs at negedge, check ready, advance one edge, check line outputs.
  task automatic step(input logic dv, input logic [7:0] b, input logic rst);
    int   cnt, nxt, st, off;
    logic exp_ready, e_ser, e_act, e_done;
    @(negedge i_Clock);
    i_Reset = rst; i_Tx_DV = dv; i_Tx_Byte = b;
    #1;
    cnt = 0;
    foreach (f_acc[i]) if (f_acc[i] <= cyc && f_st[i] - 1 > cyc) cnt++;
    exp_ready = !rst && (cnt < DEPTH);
    checks++;
    if (o_Tx_Ready !== exp_ready) begin
      failures++;
      $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_Tx_Ready, exp_ready);
    end
    nxt = cyc + 1;
    if (rst) begin
      f_acc.delete(); f_st.delete(); f_by.delete();
      last_end = -1000;
      rx_busy  = 1'b0;
    end else if (dv && exp_ready) begin
      st = (nxt + 2 > last_end + 1) ? nxt + 2 : last_end + 1;
      last_end = st + FRAME - 1;
      f_acc.push_back(nxt); f_st.push_back(st); f_by.push_back(b);
      acc_q.push_back(b);
    end
    @(posedge i_Clock);
    cyc = nxt;
    #1;
    e_ser = 1'b1; e_act = 1'b0; e_done = 1'b0;
    foreach (f_st[i]) begin
      if (cyc >= f_st[i] && cyc < f_st[i] + FRAME) begin
        off   = cyc - f_st[i];
        e_act = 1'b1;
        if (off / CPB == 0)      e_ser = 1'b0;
        else if (off / CPB <= 8) e_ser = f_by[i][off / CPB - 1];
        else                     e_ser = 1'b1;
        e_done = (off == FRAME - 1);
      end
    end
    checks++;
    if (o_Tx_Serial !== e_ser) begin
      failures++;
      $display("FAIL serial cyc=%0d got=%b exp=%b", cyc, o_Tx_Serial, e_ser);
    end
    checks++;
    if (o_Tx_Active !== e_act) begin
      failures++;
      $display("FAIL active cyc=%0d got=%b exp=%b", cyc, o_Tx_Active, e_act);
    end
    checks++;
    if (o_Tx_Done !== e_done) begin
      failures++;
      $display("FAIL done cyc=%0d got=%b exp=%b", cyc, o_Tx_Done, e_done);
    end
    if (o_Tx_Done === 1'b1) done_q.push_back(cyc);
    if (!rst) begin
      if (!rx_busy) begin
        if (o_Tx_Serial === 1'b0) begin rx_busy = 1'b1; rx_t0 = cyc; end
      end else begin
        off = cyc - rx_t0;
        if (off % CPB == CPB / 2 && off >= CPB + CPB / 2 && off <= 8 * CPB + CPB / 2)
          rx_byte[off / CPB - 1] = o_Tx_Serial;
        if (off == 9 * CPB + CPB / 2) begin
          if (o_Tx_Serial === 1'b1) rx_q.push_back(rx_byte);
          rx_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
  endtask

  task automatic clear_logs();
    rx_q.delete(); done_q.delete(); acc_q.delete();
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    checks++;
    if (rx_q.size() != exp.size()) begin
      failures++;
      $display("FAIL %s rx_count got=%0d exp=%0d", name, rx_q.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (rx_q[i] !== exp[i]) begin
          failures++;
          $display("FAIL %s rx_byte[%0d] got=%02h exp=%02h", name, i, rx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    checks++;
    if (o_Tx_Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", o_Tx_Ready);
    end
    idle(2);
    checks++;
    if (o_Tx_Ready !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got=%b exp=1", o_Tx_Ready);
    end
  endtask

  task automatic test_single();
    int base;
    logic [7:0] exp[$];
    clear_logs();
    base = cyc + 1;
    step(1'b1, 8'h55, 1'b0);
    idle(45);
    checks++;
    if (done_q.size() != 1 || done_q[0] != base + 41) begin
      failures++;
      $display("FAIL single_done got_n=%0d got_cyc=%0d exp_cyc=%0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] - base : -1, 41);
    end
    exp = '{8'h55};
    check_rx("single", exp);
  endtask

  task automatic test_back_to_back();
    int base;
    logic [7:0] exp[$];
    clear_logs();
    base = cyc + 1;
    exp = '{8'hA3, 8'h0F, 8'hFF};
    foreach (exp[i]) step(1'b1, exp[i], 1'b0);
    idle(130);
    checks++;
    if (done_q.size() != 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=3", done_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (done_q[i] != base + 41 + FRAME * i) begin
          failures++;
          $display("FAIL b2b_done[%0d] got=%0d exp=%0d", i, done_q[i] - base, 41 + FRAME * i);
        end
      end
    end
    check_rx("b2b", exp);
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    logic [7:0] exp[$];
    clear_logs();
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        checks++;
        if (o_Tx_Ready !== 1'b0) begin
          failures++;
          $display("FAIL overflow_ready got=%b exp=0", o_Tx_Ready);
        end
      end
      step(1'b1, b[i], 1'b0);
    end
    idle(215);
    for (int i = 0; i < 5; i++) exp.push_back(b[i]);
    check_rx("overflow", exp);
  endtask

  task automatic test_reset_mid_frame();
    int base;
    logic [7:0] exp[$];
    clear_logs();
    base = cyc + 1;
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b0);
    idle(base + 16 - cyc);
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) begin
      failures++;
      $display("FAIL midreset_line got=%b/%b exp=1/0", o_Tx_Serial, o_Tx_Active);
    end
    step(1'b0, 8'h00, 1'b1);
    idle(100);
    checks++;
    if (done_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_done got=%0d exp=0", done_q.size());
    end
    check_rx("midreset", exp);
  endtask

  task automatic test_idle();
    int act_hi;
    clear_logs();
    act_hi = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'($urandom), 1'b0);
      if (o_Tx_Serial !== 1'b1 || o_Tx_Active !== 1'b0) act_hi++;
    end
    checks++;
    if (act_hi != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL idle_quiet got=%0d/%0d exp=0/0", act_hi, done_q.size());
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp[$];
    clear_logs();
    exp = '{8'h00, 8'h7E, 8'h81};
    foreach (exp[i]) begin
      step(1'b1, exp[i], 1'b0);
      idle($urandom_range(0, 50));
    end
    idle(130);
    check_rx("loopback", exp);
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    clear_logs();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
    idle(260);
    exp = acc_q;
    check_rx("random", exp);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_idle();
    test_loopback();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
